pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 id_rd1_en, id_rd2_en  input  1 each  decode-stage register-read enables for ports 1 and 2.
REQ-004 id_addr1, id_addr2  input  5 each  decode-stage register-read addresses.
REQ-005 ex_mem_read  input  1  the EX-stage instruction is a load.
REQ-006 ex_wr_en, ex_wr_addr  input  1, 5  EX-stage register write enable and address.
REQ-007 ex_multi_start  input  1  single-cycle pulse; the EX-stage op needs multiple cycles.
REQ-008 ex_multi_len  input  4  total EX cycles for that op; sampled only with ex_multi_start.
REQ-009 flush_req  input  1  exception/redirect request.
REQ-010 stall  output  6  hold bits: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB.
REQ-011 flush  output  1  registered; clears the IF/ID/EX pipeline registers.
REQ-012 ex_multi_done  output  1  registered one-cycle pulse when a multi-cycle op completes.
REQ-013 busy  output  1  high whenever the state is not RUN.
REQ-014 stall_cycles  output  32  performance counter (see Configuration).

Function
REQ-015 The FSM SHALL have three states: RUN, MULTI and FLUSH. A 4-bit down-counter cnt SHALL track multi-cycle ops.
REQ-016 Load-use hazard = ex_mem_read & ex_wr_en & (ex_wr_addr!=0) & ((id_rd1_en & id_addr1==ex_wr_addr) | (id_rd2_en & id_addr2==ex_wr_addr)).
REQ-017 The stall output SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-018 In RUN with a load-use hazard and no other event, stall SHALL be 6'b000111 for that cycle only. The state SHALL stay RUN.
REQ-019 In RUN with ex_multi_start=1 and flush_req=0, stall SHALL be 6'b001111 that cycle.
  - len = ex_multi_len, with 0 treated as 1.
  - If len=1: the state SHALL stay RUN, and ex_multi_done SHALL pulse in the next cycle.
  - Otherwise: cnt SHALL load len-1 and the state SHALL go to MULTI.
REQ-020 In MULTI, stall SHALL be 6'b001111 while cnt>1, and cnt SHALL decrement each cycle.
  - The cycle with cnt==1 SHALL be the last stalled cycle.
  - The next state SHALL be RUN, with ex_multi_done=1 in that RUN cycle.
  - Total stalled cycles SHALL equal len.
REQ-021 In MULTI, ex_multi_start and the load-use hazard SHALL be ignored.
REQ-022 flush_req SHALL have highest priority in any state:
  - stall SHALL be 0 that cycle.
  - Next state SHALL be FLUSH, cnt SHALL clear, and no ex_multi_done SHALL be generated for an aborted op.
REQ-023 In FLUSH, flush SHALL be 1 for exactly one cycle and stall SHALL be 0. The next state SHALL be RUN.
  - A flush_req asserted during FLUSH SHALL re-enter FLUSH, so flush stays high.
REQ-024 Priority SHALL be: flush_req > MULTI > ex_multi_start > load-use.
REQ-025 stall[5:4] SHALL always be 0.

Reset
REQ-026 While reset=1, the module SHALL set state=RUN, cnt=0, flush=0, ex_multi_done=0 and stall_cycles=0. stall SHALL be forced to 0 combinationally.
REQ-027 Reset asserted mid-MULTI or mid-FLUSH SHALL abort the op with no ex_multi_done and no flush pulse.

Configuration
REQ-028 With PIPE_CTRL_PERF_EN defined, stall_cycles SHALL increment by 1 every cycle that stall[2]=1, saturating at 32'hFFFF_FFFF.
REQ-029 Without PIPE_CTRL_PERF_EN, the stall_cycles port SHALL remain and be tied to 0, and no counter logic SHALL exist.

Verification
REQ-030 Load-use: ex_mem_read=1, ex_wr_en=1, ex_wr_addr=5, id_rd2_en=1, id_addr2=5 -> stall=000111 for 1 cycle; ex_wr_addr=0 -> stall=0.
REQ-031 ex_multi_start with len=4 -> stall=001111 for exactly 4 cycles, ex_multi_done in cycle 5, busy high for cycles 2-4; len=0 -> 1 stalled cycle, done next cycle.
REQ-032 flush_req in the 2nd cycle of a len=8 op -> stall=0 that cycle, flush=1 next cycle only, no ex_multi_done, then RUN.
REQ-033 flush_req, ex_multi_start and load-use in the same cycle -> stall=0, flush next cycle, no MULTI entry.
REQ-034 reset during MULTI (cnt=3) -> next cycle stall=0, busy=0, no ex_multi_done.
REQ-035 PIPE_CTRL_PERF_EN defined: a len=4 op plus one load-use stall -> stall_cycles=5; undefined -> stall_cycles=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, multi-cycle EX ops and flush sequencing.
// Optional stall performance counter enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_rd1_en,
  input  logic        id_rd2_en,
  input  logic [4:0]  id_addr1,
  input  logic [4:0]  id_addr2,
  input  logic        ex_mem_read,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_addr,
  input  logic        ex_multi_start,
  input  logic [3:0]  ex_multi_len,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        ex_multi_done,
  output logic        busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, MULTI, FLUSH} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       flush_q;
  logic       done_q, done_d;
  logic       load_use;
  logic [3:0] len;

  assign load_use = ex_mem_read & ex_wr_en & (ex_wr_addr != 5'd0) &
                    ((id_rd1_en & (id_addr1 == ex_wr_addr)) |
                     (id_rd2_en & (id_addr2 == ex_wr_addr)));

  // A zero length request still occupies EX for one cycle.
  assign len = (ex_multi_len == 4'd0) ? 4'd1 : ex_multi_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= (state_d == FLUSH);
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (flush_req) begin
      state_d = FLUSH;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_multi_start) begin
            if (len == 4'd1) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = len - 4'd1;
              state_d = MULTI;
            end
          end
        end
        MULTI: begin
          // cnt==1 is the final stalled cycle; completion is flagged in the following RUN cycle.
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (!reset && !flush_req) begin
      case (state_q)
        RUN: begin
          if (ex_multi_start)
            stall = 6'b001111;
          else if (load_use)
            stall = 6'b000111;
        end
        MULTI:   stall = 6'b001111;
        default: stall = 6'b000000;
      endcase
    end
  end

  assign busy          = (state_q != RUN);
  assign flush         = flush_q;
  assign ex_multi_done = done_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles_q <= 32'd0;
    else if (stall[2] && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_q <= stall_cycles_q + 32'd1;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of load-use vectors plus hand-written
// multi-cycle, flush, reset and performance-counter sequences.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       rd1;
    logic [4:0] a1;
    logic       rd2;
    logic [4:0] a2;
    logic       memRead;
    logic       wrEn;
    logic [4:0] wrAddr;
    logic       start;
    logic [3:0] len;
    logic       flushReq;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [5:0] expStall;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_rd1_en = 1'b0, id_rd2_en = 1'b0;
  logic [4:0]  id_addr1 = 5'd0, id_addr2 = 5'd0;
  logic        ex_mem_read = 1'b0, ex_wr_en = 1'b0;
  logic [4:0]  ex_wr_addr = 5'd0;
  logic        ex_multi_start = 1'b0;
  logic [3:0]  ex_multi_len = 4'd0;
  logic        flush_req = 1'b0;
  logic [5:0]  stall;
  logic        flush, ex_multi_done, busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .id_rd1_en     (id_rd1_en),
    .id_rd2_en     (id_rd2_en),
    .id_addr1      (id_addr1),
    .id_addr2      (id_addr2),
    .ex_mem_read   (ex_mem_read),
    .ex_wr_en      (ex_wr_en),
    .ex_wr_addr    (ex_wr_addr),
    .ex_multi_start(ex_multi_start),
    .ex_multi_len  (ex_multi_len),
    .flush_req     (flush_req),
    .stall         (stall),
    .flush         (flush),
    .ex_multi_done (ex_multi_done),
    .busy          (busy),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t hazardStim(input logic rd1, input logic [4:0] a1,
                                       input logic rd2, input logic [4:0] a2,
                                       input logic memRead, input logic wrEn,
                                       input logic [4:0] wrAddr);
    stim_t s;
    s = '0;
    s.rd1 = rd1; s.a1 = a1; s.rd2 = rd2; s.a2 = a2;
    s.memRead = memRead; s.wrEn = wrEn; s.wrAddr = wrAddr;
    return s;
  endfunction

  function automatic stim_t startStim(input logic [3:0] len);
    stim_t s;
    s = '0;
    s.start = 1'b1;
    s.len = len;
    return s;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later, mid-cycle.
  task automatic applyStimulus(input stim_t s, input logic rst);
    @(negedge clk);
    reset          = rst;
    id_rd1_en      = s.rd1;
    id_addr1       = s.a1;
    id_rd2_en      = s.rd2;
    id_addr2       = s.a2;
    ex_mem_read    = s.memRead;
    ex_wr_en       = s.wrEn;
    ex_wr_addr     = s.wrAddr;
    ex_multi_start = s.start;
    ex_multi_len   = s.len;
    flush_req      = s.flushReq;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs[9];
    stim_t s;

    vecs[0] = '{"lu_port2_addr5",  hazardStim(0, 5'd0,  1, 5'd5,  1, 1, 5'd5),  6'b000111};
    vecs[1] = '{"lu_waddr0",       hazardStim(0, 5'd0,  1, 5'd0,  1, 1, 5'd0),  6'b000000};
    vecs[2] = '{"lu_port1_addr31", hazardStim(1, 5'd31, 0, 5'd0,  1, 1, 5'd31), 6'b000111};
    vecs[3] = '{"lu_rd1_disabled", hazardStim(0, 5'd31, 0, 5'd0,  1, 1, 5'd31), 6'b000000};
    vecs[4] = '{"lu_not_load",     hazardStim(1, 5'd7,  1, 5'd7,  0, 1, 5'd7),  6'b000000};
    vecs[5] = '{"lu_no_write",     hazardStim(1, 5'd7,  1, 5'd7,  1, 0, 5'd7),  6'b000000};
    vecs[6] = '{"lu_addr_miss",    hazardStim(1, 5'd6,  1, 5'd8,  1, 1, 5'd7),  6'b000000};
    vecs[7] = '{"lu_both_match",   hazardStim(1, 5'd12, 1, 5'd12, 1, 1, 5'd12), 6'b000111};
    vecs[8] = '{"lu_match_disabled", hazardStim(0, 5'd9, 1, 5'd3, 1, 1, 5'd9),  6'b000000};

    // Reset forces stall low even with a hazard present.
    applyStimulus(vecs[0].s, 1'b1);
    checkOutput("reset_stall_forced", {26'd0, stall}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_flush", {31'd0, flush}, 32'd0);
    checkOutput("reset_done", {31'd0, ex_multi_done}, 32'd0);
    checkOutput("reset_stall_cycles", stall_cycles, 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].s, 1'b0);
      checkOutput({vecs[i].name, "_stall"}, {26'd0, stall}, {26'd0, vecs[i].expStall});
      checkOutput({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd0);
    end
    applyStimulus(idle(), 1'b0);
    checkOutput("lu_one_cycle_only", {26'd0, stall}, 32'd0);

    // len=4: four stalled cycles, done in cycle 5; hazards and restarts ignored in MULTI.
    applyStimulus(startStim(4'd4), 1'b0);
    checkOutput("m4_c1_stall", {26'd0, stall}, {26'd0, 6'b001111});
    checkOutput("m4_c1_busy", {31'd0, busy}, 32'd0);
    applyStimulus(vecs[0].s, 1'b0);
    checkOutput("m4_c2_stall", {26'd0, stall}, {26'd0, 6'b001111});
    checkOutput("m4_c2_busy", {31'd0, busy}, 32'd1);
    applyStimulus(startStim(4'd9), 1'b0);
    checkOutput("m4_c3_stall", {26'd0, stall}, {26'd0, 6'b001111});
    checkOutput("m4_c3_busy", {31'd0, busy}, 32'd1);
    checkOutput("m4_c3_done", {31'd0, ex_multi_done}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("m4_c4_stall", {26'd0, stall}, {26'd0, 6'b001111});
    checkOutput("m4_c4_busy", {31'd0, busy}, 32'd1);
    checkOutput("m4_c4_done", {31'd0, ex_multi_done}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("m4_c5_stall", {26'd0, stall}, 32'd0);
    checkOutput("m4_c5_busy", {31'd0, busy}, 32'd0);
    checkOutput("m4_c5_done", {31'd0, ex_multi_done}, 32'd1);
    applyStimulus(idle(), 1'b0);
    checkOutput("m4_c6_done_pulse", {31'd0, ex_multi_done}, 32'd0);

    // len=0 behaves as a single stalled cycle.
    applyStimulus(startStim(4'd0), 1'b0);
    checkOutput("m0_c1_stall", {26'd0, stall}, {26'd0, 6'b001111});
    applyStimulus(idle(), 1'b0);
    checkOutput("m0_c2_stall", {26'd0, stall}, 32'd0);
    checkOutput("m0_c2_busy", {31'd0, busy}, 32'd0);
    checkOutput("m0_c2_done", {31'd0, ex_multi_done}, 32'd1);
    applyStimulus(idle(), 1'b0);
    checkOutput("m0_c3_done", {31'd0, ex_multi_done}, 32'd0);

    // Flush in the second cycle of a len=8 op aborts it.
    applyStimulus(startStim(4'd8), 1'b0);
    checkOutput("f8_c1_stall", {26'd0, stall}, {26'd0, 6'b001111});
    s = idle();
    s.flushReq = 1'b1;
    applyStimulus(s, 1'b0);
    checkOutput("f8_c2_stall", {26'd0, stall}, 32'd0);
    checkOutput("f8_c2_busy", {31'd0, busy}, 32'd1);
    applyStimulus(idle(), 1'b0);
    checkOutput("f8_c3_flush", {31'd0, flush}, 32'd1);
    checkOutput("f8_c3_stall", {26'd0, stall}, 32'd0);
    checkOutput("f8_c3_done", {31'd0, ex_multi_done}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("f8_c4_flush", {31'd0, flush}, 32'd0);
    checkOutput("f8_c4_busy", {31'd0, busy}, 32'd0);
    checkOutput("f8_c4_done", {31'd0, ex_multi_done}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("f8_c5_done", {31'd0, ex_multi_done}, 32'd0);

    // Flush, multi-start and load-use together: flush wins, MULTI never entered.
    s = vecs[0].s;
    s.start = 1'b1;
    s.len = 4'd6;
    s.flushReq = 1'b1;
    applyStimulus(s, 1'b0);
    checkOutput("fall_c1_stall", {26'd0, stall}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("fall_c2_flush", {31'd0, flush}, 32'd1);
    checkOutput("fall_c2_busy", {31'd0, busy}, 32'd1);
    applyStimulus(idle(), 1'b0);
    checkOutput("fall_c3_flush", {31'd0, flush}, 32'd0);
    checkOutput("fall_c3_busy", {31'd0, busy}, 32'd0);
    checkOutput("fall_c3_done", {31'd0, ex_multi_done}, 32'd0);

    // A flush request while in FLUSH keeps flush asserted.
    s = idle();
    s.flushReq = 1'b1;
    applyStimulus(s, 1'b0);
    applyStimulus(s, 1'b0);
    checkOutput("fre_c2_flush", {31'd0, flush}, 32'd1);
    checkOutput("fre_c2_stall", {26'd0, stall}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("fre_c3_flush", {31'd0, flush}, 32'd1);
    applyStimulus(idle(), 1'b0);
    checkOutput("fre_c4_flush", {31'd0, flush}, 32'd0);
    checkOutput("fre_c4_busy", {31'd0, busy}, 32'd0);

    // Reset while MULTI holds cnt=3 aborts without a done pulse.
    applyStimulus(startStim(4'd5), 1'b0);
    applyStimulus(idle(), 1'b0);
    checkOutput("rm_c2_busy", {31'd0, busy}, 32'd1);
    applyStimulus(idle(), 1'b1);
    checkOutput("rm_c3_stall_forced", {26'd0, stall}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("rm_c4_stall", {26'd0, stall}, 32'd0);
    checkOutput("rm_c4_busy", {31'd0, busy}, 32'd0);
    checkOutput("rm_c4_done", {31'd0, ex_multi_done}, 32'd0);
    applyStimulus(idle(), 1'b0);
    checkOutput("rm_c5_done", {31'd0, ex_multi_done}, 32'd0);
    checkOutput("rm_c5_flush", {31'd0, flush}, 32'd0);

    // Performance counter: a len=4 op plus one load-use stall from a clean reset.
    applyStimulus(idle(), 1'b1);
    applyStimulus(startStim(4'd4), 1'b0);
    applyStimulus(idle(), 1'b0);
    applyStimulus(idle(), 1'b0);
    applyStimulus(idle(), 1'b0);
    applyStimulus(idle(), 1'b0);
    applyStimulus(vecs[0].s, 1'b0);
    applyStimulus(idle(), 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("perf_stall_cycles", stall_cycles, 32'd5);
`else
    checkOutput("perf_stall_cycles", stall_cycles, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
